// File: rtl/ss_pkg.sv
// ss_pkg: shared state encoding, job/result counts and watchdog default for ss_sched.
package ss_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, WAIT, DRAIN} state_e;
    localparam int WORDS_2X2 = 8;
    localparam int WORDS_4X4 = 32;
    localparam int RES_2X2 = 3;
    localparam int RES_4X4 = 7;
    localparam int WD_LIMIT_DEF = 31;
    function automatic logic [5:0] last_word(input logic sz);
        return sz ? 6'(WORDS_4X4 - 1) : 6'(WORDS_2X2 - 1);
    endfunction
    function automatic logic [5:0] last_res(input logic sz);
        return sz ? 6'(RES_4X4 - 1) : 6'(RES_2X2 - 1);
    endfunction
endpackage

// File: rtl/ss_rr_arb.sv
// ss_rr_arb: two-way round-robin arbiter; the pointer side wins when both request.
module ss_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb gnt = &req ? (ptr ? 2'b10 : 2'b01) : (req[0] ? 2'b01 : {req[1], 1'b0});
endmodule

// File: rtl/ss_sched.sv
// ss_sched: two-requester job scheduler streaming words to a systolic array and routing results back.
module ss_sched import ss_pkg::*; #(
    parameter int WD_LIMIT = WD_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  req_size,
    input  logic [15:0] req_data0,
    input  logic [15:0] req_data1,
    output logic [1:0]  pop,
    output logic [1:0]  grant,
    output logic        ss_in_valid,
    output logic [15:0] ss_matrix,
    output logic        ss_matrix_size,
    input  logic        ss_out_valid,
    input  logic [39:0] ss_out_value,
    output logic [1:0]  res_valid,
    output logic [39:0] res_value,
    output logic [1:0]  done,
    output logic        err
);
    localparam int WDW = $clog2(WD_LIMIT + 2);
    state_e          state_q, state_d;
    logic            ptr_q, ptr_d, size_q, size_d;
    logic [1:0]      grant_q, grant_d, arb_gnt;
    logic [5:0]      cnt_q, cnt_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            in_valid_q, in_valid_d, msize_q, msize_d, err_q, err_d;
    logic [15:0]     matrix_q, matrix_d, word;
    logic [1:0]      res_valid_q, res_valid_d, done_q, done_d;
    logic [39:0]     res_value_q, res_value_d;
    logic            fwd, end_job;

    ss_rr_arb u_arb (.req(req), .ptr(ptr_q), .gnt(arb_gnt));

    assign word = grant_q[1] ? req_data1 : req_data0;

    // cnt_q counts popped words in STREAM and forwarded results in WAIT/DRAIN
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        grant_d = grant_q;
        size_d = size_q;
        cnt_d = cnt_q;
        wd_d = wd_q;
        pop = 2'b00;
        err_d = 1'b0;
        done_d = 2'b00;
        fwd = 1'b0;
        end_job = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                grant_d = arb_gnt;
                size_d = |(req_size & arb_gnt);
                cnt_d = '0;
                state_d = STREAM;
            end
            STREAM: begin
                pop = grant_q;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == last_word(size_q)) begin
                    cnt_d = '0;
                    wd_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: if (ss_out_valid) begin
                fwd = 1'b1;
                cnt_d = 6'd1;
                state_d = DRAIN;
            end else if (wd_q == WDW'(WD_LIMIT)) begin
                err_d = 1'b1;
                end_job = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
            DRAIN: if (ss_out_valid) begin
                fwd = 1'b1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == last_res(size_q)) begin
                    done_d = grant_q;
                    end_job = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (end_job) begin
            state_d = IDLE;
            grant_d = 2'b00;
            ptr_d = ~ptr_q;
            cnt_d = '0;
        end
        res_valid_d = fwd ? grant_q : 2'b00;
        res_value_d = fwd ? ss_out_value : 40'd0;
        in_valid_d = |pop;
        matrix_d = |pop ? word : 16'd0;
        msize_d = |pop & size_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= 1'b0;
            grant_q <= 2'b00;
            size_q <= 1'b0;
            cnt_q <= '0;
            wd_q <= '0;
            in_valid_q <= 1'b0;
            matrix_q <= '0;
            msize_q <= 1'b0;
            res_valid_q <= 2'b00;
            res_value_q <= '0;
            done_q <= 2'b00;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            grant_q <= grant_d;
            size_q <= size_d;
            cnt_q <= cnt_d;
            wd_q <= wd_d;
            in_valid_q <= in_valid_d;
            matrix_q <= matrix_d;
            msize_q <= msize_d;
            res_valid_q <= res_valid_d;
            res_value_q <= res_value_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end

    assign grant = grant_q;
    assign ss_in_valid = in_valid_q;
    assign ss_matrix = matrix_q;
    assign ss_matrix_size = msize_q;
    assign res_valid = res_valid_q;
    assign res_value = res_value_q;
    assign done = done_q;
    assign err = err_q;
endmodule

// File: tb/tb_ss_sched.sv
// tb_ss_sched: directed scoreboard bench for ss_sched.
module tb_ss_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, req_size, pop, grant, res_valid, done;
    logic [15:0] req_data0, req_data1, ss_matrix;
    logic        ss_in_valid, ss_matrix_size, ss_out_valid, err;
    logic [39:0] ss_out_value, res_value;

    ss_sched dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_size(req_size),
        .req_data0(req_data0), .req_data1(req_data1), .pop(pop), .grant(grant),
        .ss_in_valid(ss_in_valid), .ss_matrix(ss_matrix), .ss_matrix_size(ss_matrix_size),
        .ss_out_valid(ss_out_valid), .ss_out_value(ss_out_value),
        .res_valid(res_valid), .res_value(res_value), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc_n = 0, pop_n = 0, pop_runs = 0, err_n = 0, last_pop = 0, err_cyc = -1;
    logic [15:0] q0[$], q1[$];
    logic [16:0] mq[$];
    logic [43:0] rq[$];
    logic        cur_sz = 1'b0, en = 1'b0;
    logic [1:0]  prev_pop = 2'b00, prev_grant = 2'b00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ctl"}, {pop, grant, ss_in_valid, ss_matrix_size, res_valid, done, err}, 64'd0);
        chk({tag, "_data"}, {ss_matrix, res_value}, 64'd0);
    endtask

    // One clock: consume popped words into the stream scoreboard, then check registered outputs.
    task automatic tick();
        logic [1:0]  p;
        logic [15:0] w;
        logic [16:0] m;
        logic [43:0] r;
        p = pop;
        if (!rst_n) begin
            mq.delete();
            rq.delete();
        end else if (p != 2'b00) begin
            if (en) chk("pop_owner", p, grant);
            w = 16'hdead;
            if (p[0] && q0.size() > 0) w = q0.pop_front();
            if (p[1] && q1.size() > 0) w = q1.pop_front();
            mq.push_back({cur_sz, w});
            pop_n++;
            if (prev_pop == 2'b00) pop_runs++;
            last_pop = cyc_n;
        end
        prev_pop = p;
        @(posedge clk);
        #1;
        cyc_n++;
        req_data0 = q0.size() > 0 ? q0[0] : 16'h0;
        req_data1 = q1.size() > 0 ? q1[0] : 16'h0;
        if (err) begin
            err_n++;
            err_cyc = cyc_n;
        end
        if (en) begin
            if (mq.size() > 0) begin
                m = mq.pop_front();
                chk("stream", {ss_in_valid, ss_matrix_size, ss_matrix}, {1'b1, m});
            end else begin
                chk("stream_off", {ss_in_valid, ss_matrix}, 64'd0);
            end
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("result", {done, res_valid, res_value}, r);
            end else begin
                chk("no_result", {done, res_valid, res_value}, 64'd0);
            end
            if (done != 2'b00 || err) chk("grant_at_end", grant, 2'b00);
            if (prev_grant != 2'b00 && grant != 2'b00) chk("grant_held", grant, prev_grant);
        end
        prev_grant = grant;
    endtask

    task automatic load(input int r, input logic sz, input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            if (r == 0) q0.push_back(base + 16'(k));
            else q1.push_back(base + 16'(k));
        end
        req[r] = 1'b1;
        req_size[r] = sz;
        cur_sz = sz;
        req_data0 = q0.size() > 0 ? q0[0] : 16'h0;
        req_data1 = q1.size() > 0 ? q1[0] : 16'h0;
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int g = 0;
        while (grant == 2'b00 && g < 20) begin
            tick();
            g++;
        end
        chk(tag, grant, exp);
        pop_n = 0;
        pop_runs = 0;
    endtask

    task automatic wait_stream(input string tag, input int n);
        int g = 0;
        while (pop_n < n && g < 100) begin
            tick();
            g++;
        end
        chk({tag, "_pops"}, pop_n, n);
        chk({tag, "_runs"}, pop_runs, 1);
        chk({tag, "_pop_stop"}, pop, 2'b00);
    endtask

    task automatic send_res(input int r, input logic [39:0] val, input logic last);
        logic [1:0] oh;
        oh = 2'(1 << r);
        ss_out_valid = 1'b1;
        ss_out_value = val;
        rq.push_back({last ? oh : 2'b00, oh, val});
        tick();
        ss_out_valid = 1'b0;
        ss_out_value = '0;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        req = 2'b00;
        req_size = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        ss_out_valid = 1'b0;
        ss_out_value = '0;
        repeat (2) tick();
        en = 1'b1;
        chk_rst("reset");
        rst_n = 1'b1;
        // single 2x2 job; a stray array result during STREAM must be dropped
        load(0, 1'b0, 16'd1, 8);
        wait_grant("t1_grant", 2'b01);
        req = 2'b00;
        ss_out_valid = 1'b1;
        ss_out_value = 40'd999;
        tick();
        ss_out_valid = 1'b0;
        ss_out_value = '0;
        wait_stream("t1", 8);
        send_res(0, 40'd10, 1'b0);
        send_res(0, 40'd20, 1'b0);
        send_res(0, 40'd30, 1'b1);
        tick();
        // back-to-back contention from reset: 0, 1, 0
        rst_n = 1'b0;
        tick();
        chk_rst("t2_reset");
        rst_n = 1'b1;
        load(0, 1'b0, 16'h100, 16);
        load(1, 1'b0, 16'h200, 8);
        wait_grant("t2_g0", 2'b01);
        wait_stream("t2a", 8);
        send_res(0, 40'h11, 1'b0);
        send_res(0, 40'h12, 1'b0);
        send_res(0, 40'h13, 1'b1);
        wait_grant("t2_g1", 2'b10);
        req[1] = 1'b0;
        wait_stream("t2b", 8);
        send_res(1, 40'h21, 1'b0);
        send_res(1, 40'h22, 1'b0);
        send_res(1, 40'h23, 1'b1);
        wait_grant("t2_g2", 2'b01);
        req = 2'b00;
        wait_stream("t2c", 8);
        send_res(0, 40'h31, 1'b0);
        send_res(0, 40'h32, 1'b0);
        send_res(0, 40'h33, 1'b1);
        // 4x4 job with a gap in the result stream
        load(1, 1'b1, 16'h300, 32);
        wait_grant("t3_grant", 2'b10);
        req = 2'b00;
        wait_stream("t3", 32);
        send_res(1, 40'hA000000001, 1'b0);
        send_res(1, 40'hA000000002, 1'b0);
        send_res(1, 40'hA000000003, 1'b0);
        repeat (2) tick();
        send_res(1, 40'hA000000004, 1'b0);
        send_res(1, 40'hA000000005, 1'b0);
        send_res(1, 40'hA000000006, 1'b0);
        send_res(1, 40'hFFFFFFFFFF, 1'b1);
        // watchdog: no results at all
        load(0, 1'b0, 16'h400, 8);
        wait_grant("t4_grant", 2'b01);
        req = 2'b00;
        wait_stream("t4", 8);
        g = 0;
        while (err_n == 0 && g < 60) begin
            tick();
            g++;
        end
        chk("t4_wd_cycle", err_cyc, last_pop + 33);
        chk("t4_grant_drop", grant, 2'b00);
        load(1, 1'b0, 16'h500, 8);
        req[0] = 1'b1;
        tick();
        chk("t4_ptr_flip", grant, 2'b10);
        wait_grant("t4_grant2", 2'b10);
        req = 2'b00;
        wait_stream("t4b", 8);
        send_res(1, 40'h41, 1'b0);
        send_res(1, 40'h42, 1'b0);
        send_res(1, 40'h43, 1'b1);
        // reset in the middle of a 4x4 stream
        load(1, 1'b1, 16'h600, 32);
        wait_grant("t5_grant", 2'b10);
        req = 2'b00;
        g = 0;
        while (pop_n < 4 && g < 20) begin
            tick();
            g++;
        end
        chk("t5_word5", pop, 2'b10);
        rst_n = 1'b0;
        tick();
        chk_rst("t5_reset");
        q1.delete();
        rst_n = 1'b1;
        load(0, 1'b0, 16'h700, 8);
        load(1, 1'b0, 16'h800, 8);
        wait_grant("t5_ptr_reset", 2'b01);
        req = 2'b00;
        q1.delete();
        wait_stream("t5b", 8);
        send_res(0, 40'h51, 1'b0);
        send_res(0, 40'h52, 1'b0);
        send_res(0, 40'h53, 1'b1);
        // request dropped mid-stream
        load(0, 1'b0, 16'h900, 8);
        wait_grant("t6_grant", 2'b01);
        g = 0;
        while (pop_n < 3 && g < 20) begin
            tick();
            g++;
        end
        req = 2'b00;
        wait_stream("t6", 8);
        send_res(0, 40'h61, 1'b0);
        send_res(0, 40'h62, 1'b0);
        send_res(0, 40'h63, 1'b1);
        repeat (3) tick();
        chk("t6_idle", grant, 2'b00);
        chk("err_once", err_n, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
